// File: rtl/moving_average_nch.sv
// moving_average_nch
//   Multi-channel boxcar (moving-average) low-pass filter for the codec sample
//   path. Each channel keeps a circular delay line of 2**LOG2_DEPTH samples and
//   a full-precision running sum. The output is that sum shifted down by
//   LOG2_DEPTH bits, which is the window average rounded toward -inf. A bypass
//   mode outputs the raw input instead.
//
//   Ports
//     CLOCK_50   in   system clock, rising edge
//     reset      in   asynchronous active-low reset
//     in_valid   in   one sample set on in_data this cycle
//     in_data    in   CHANNELS x WIDTH signed samples, channel c at [c*WIDTH +: WIDTH]
//     bypass     in   1 = output raw input, 0 = output window average
//     flush      in   synchronous clear of window, accumulators and fill state
//     out_valid  out  one-cycle strobe, out_data valid
//     out_data   out  CHANNELS x WIDTH signed results, same packing as in_data
//     filled     out  window holds 2**LOG2_DEPTH real samples
//     state_dbg  out  current FSM state (0 = FILL, 1 = RUN)
//
//   Handshake: in_valid is a one-cycle qualifier with no ready. Every in_valid
//   cycle without flush is accepted. Each accepted sample produces exactly one
//   out_valid strobe on the following cycle. There is no backpressure, so the
//   consumer must take every strobe.
module moving_average_nch #(
  parameter int WIDTH      = 24,
  parameter int LOG2_DEPTH = 6,
  parameter int CHANNELS   = 2
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      bypass,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      filled,
  output logic                      state_dbg
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int AW    = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] LAST_IDX = LOG2_DEPTH'(DEPTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [LOG2_DEPTH-1:0]   wr_ptr;
  logic [LOG2_DEPTH-1:0]   fill_cnt;
  logic signed [AW-1:0]    acc     [CHANNELS];
  logic signed [AW-1:0]    acc_nxt [CHANNELS];
  logic signed [AW-1:0]    in_ext  [CHANNELS];
  logic signed [AW-1:0]    old_ext [CHANNELS];
  logic [WIDTH-1:0]        delay_line [CHANNELS][DEPTH];
  logic [CHANNELS*WIDTH-1:0] out_nxt;
  logic                    accept;

  // flush takes priority: a sample presented together with flush is dropped.
  assign accept    = in_valid && !flush;
  assign state_dbg = state;

  // Running-sum update and output selection. The word at wr_ptr is the oldest
  // sample; during FILL it is stale memory, so it is treated as zero.
  always_comb begin
    out_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_ext[c] = AW'($signed(in_data[c*WIDTH +: WIDTH]));
      if (state == RUN) begin
        old_ext[c] = AW'($signed(delay_line[c][wr_ptr]));
      end else begin
        old_ext[c] = '0;
      end
      acc_nxt[c] = acc[c] + in_ext[c] - old_ext[c];
      // The top WIDTH bits of the sum equal (sum >>> LOG2_DEPTH) truncated to
      // WIDTH. The average of WIDTH-bit values always fits in WIDTH bits.
      if (bypass) begin
        out_nxt[c*WIDTH +: WIDTH] = in_data[c*WIDTH +: WIDTH];
      end else begin
        out_nxt[c*WIDTH +: WIDTH] = acc_nxt[c][AW-1:LOG2_DEPTH];
      end
    end
  end

  // The delay line has no reset. The FILL state masks its stale contents.
  always_ff @(posedge CLOCK_50) begin
    if (reset && accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        delay_line[c][wr_ptr] <= in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      filled    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
      end
    end else if (flush) begin
      state     <= FILL;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      filled    <= 1'b0;
      out_valid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
      end
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int c = 0; c < CHANNELS; c++) begin
          acc[c] <= acc_nxt[c];
        end
        wr_ptr   <= wr_ptr + 1'b1;
        out_data <= out_nxt;
        case (state)
          FILL: begin
            // On the sample that completes the window, filled rises together
            // with that sample's out_valid.
            if (fill_cnt == LAST_IDX) begin
              state    <= RUN;
              filled   <= 1'b1;
              fill_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          RUN: begin
            state <= RUN;
          end
          default: begin
            state <= FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moving_average_nch.sv
// tb_moving_average_nch
//   Bench for moving_average_nch with WIDTH=24, LOG2_DEPTH=2, CHANNELS=2.
//   Expected words {filled, ch1, ch0} are queued as samples are driven. They
//   come either from a table of hand-computed vectors or from a window-sum
//   model. A negedge monitor pops one word for each out_valid and also checks
//   one-cycle latency against the bench's own view of accepted samples.
module tb_moving_average_nch;

  localparam int WIDTH = 24;
  localparam int LOG2D = 2;
  localparam int CH    = 2;
  localparam int W     = CH*WIDTH + 1;

  logic                  CLOCK_50;
  logic                  reset = 1'b0;
  logic                  in_valid = 1'b0;
  logic [CH*WIDTH-1:0]   in_data = '0;
  logic                  bypass = 1'b0;
  logic                  flush = 1'b0;
  logic                  out_valid;
  logic [CH*WIDTH-1:0]   out_data;
  logic                  filled;
  logic                  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic want_valid = 1'b0;

  moving_average_nch #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2D), .CHANNELS(CH)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .bypass    (bypass),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .filled    (filled),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // A sample accepted at a posedge must give out_valid for the next cycle.
  always @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) want_valid <= 1'b0;
    else        want_valid <= in_valid && !flush;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLOCK_50) begin
    logic [W-1:0] exp_w;
    logic [W-1:0] got_w;
    if (reset) begin
      if (out_valid || want_valid) begin
        checks++;
        if (out_valid !== want_valid) begin
          errors++;
          $display("FAIL out_valid_timing got %b want %b", out_valid, want_valid);
        end
      end
      if (out_valid) begin
        got_w = {filled, out_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h want none", got_w);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            errors++;
            $display("FAIL output_word got filled=%b ch1=%h ch0=%h want filled=%b ch1=%h ch0=%h",
                     got_w[W-1], got_w[2*WIDTH-1:WIDTH], got_w[WIDTH-1:0],
                     exp_w[W-1], exp_w[2*WIDTH-1:WIDTH], exp_w[WIDTH-1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  longint win0[4];
  longint win1[4];
  int     mwp;
  int     mwn;

  function automatic longint fdiv4(input longint s);
    longint q;
    q = s / 4;
    if ((s % 4) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      win0[i] = 0;
      win1[i] = 0;
    end
    mwp = 0;
    mwn = 0;
  endfunction

  // ---------------- driver tasks (called just after a posedge) ----------------
  task automatic drive(input int c0, input int c1, input bit byp);
    logic [WIDTH-1:0] t0;
    logic [WIDTH-1:0] t1;
    t0 = c0[WIDTH-1:0];
    t1 = c1[WIDTH-1:0];
    in_data  = {t1, t0};
    bypass   = byp;
    in_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input int c0, input int c1, input bit byp,
                          input int e0, input int e1, input bit ef);
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    x0 = e0[WIDTH-1:0];
    x1 = e1[WIDTH-1:0];
    exp_q.push_back({ef, x1, x0});
    drive(c0, c1, byp);
  endtask

  task automatic send_model(input int c0, input int c1, input bit byp);
    longint s0;
    longint s1;
    longint q0;
    longint q1;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    win0[mwp] = c0;
    win1[mwp] = c1;
    mwp = (mwp + 1) % 4;
    if (mwn < 4) mwn++;
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < 4; i++) begin
      s0 += win0[i];
      s1 += win1[i];
    end
    q0 = byp ? longint'(c0) : fdiv4(s0);
    q1 = byp ? longint'(c1) : fdiv4(s1);
    r0 = q0[WIDTH-1:0];
    r1 = q1[WIDTH-1:0];
    exp_q.push_back({(mwn == 4), r1, r0});
    drive(c0, c1, byp);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge CLOCK_50);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit clr;
    bit byp;
    int gap;
    int d0;
    int d1;
    int e0;
    int e1;
    bit ef;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit clr, input bit byp, input int gap,
                     input int d0, input int d1, input int e0, input int e1, input bit ef);
    vec_t v;
    v.clr = clr; v.byp = byp; v.gap = gap;
    v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1; v.ef = ef;
    tbl.push_back(v);
  endtask

  localparam int PMAX = 8388607;
  localparam int NMIN = -8388608;

  initial begin
    // step of 400 on ch0
    add(1, 0, 0, 400, 0, 100, 0, 0);
    add(0, 0, 0, 400, 0, 200, 0, 0);
    add(0, 0, 0, 400, 0, 300, 0, 0);
    add(0, 0, 0, 400, 0, 400, 0, 1);
    add(0, 0, 0, 400, 0, 400, 0, 1);
    add(0, 0, 0, 400, 0, 400, 0, 1);
    // constant -8 on ch1, with idle gaps between samples
    add(1, 0, 2, 0, -8, 0, -2, 0);
    add(0, 0, 2, 0, -8, 0, -4, 0);
    add(0, 0, 2, 0, -8, 0, -6, 0);
    add(0, 0, 2, 0, -8, 0, -8, 1);
    add(0, 0, 2, 0, -8, 0, -8, 1);
    // positive impulse floors to 0
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // negative impulse floors to -1 until it leaves the window
    add(1, 0, 0, -1, 0, -1, 0, 0);
    add(0, 0, 0, 0, 0, -1, 0, 0);
    add(0, 0, 0, 0, 0, -1, 0, 0);
    add(0, 0, 0, 0, 0, -1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // positive full scale, then negative full scale
    add(1, 0, 0, PMAX, 0, 2097151, 0, 0);
    add(0, 0, 0, PMAX, 0, 4194303, 0, 0);
    add(0, 0, 0, PMAX, 0, 6291455, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, PMAX, 0, PMAX, 0, 1);
    add(0, 0, 0, NMIN, 0, 4194303, 0, 1);
    add(0, 0, 0, NMIN, 0, -1, 0, 1);
    add(0, 0, 0, NMIN, 0, -4194305, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 0, NMIN, 0, NMIN, 0, 1);
    // bypass with one idle cycle between pulses, then average mode mid-stream
    add(1, 1, 1, 5, 0, 5, 0, 0);
    add(0, 1, 1, -3, 0, -3, 0, 0);
    add(0, 0, 1, 8, 0, 2, 0, 0);
    add(0, 0, 1, 4, 0, 3, 0, 1);
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_filled", 64'(filled), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    reset = 1'b1;
    idle(1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].clr) do_flush();
      send_exp(tbl[i].d0, tbl[i].d1, tbl[i].byp, tbl[i].e0, tbl[i].e1, tbl[i].ef);
      idle(tbl[i].gap);
    end

    // flush together with a sample: the sample is dropped, window restarts.
    check("filled_before_flush", 64'(filled), 64'd1);
    in_data  = {24'd999, 24'd999};
    in_valid = 1'b1;
    bypass   = 1'b0;
    do_flush();
    in_valid = 1'b0;
    check("filled_after_flush", 64'(filled), 64'd0);
    check("state_after_flush", 64'(state_dbg), 64'd0);
    idle(1);
    send_exp(40, -40, 0, 10, -10, 0);
    send_exp(40, -40, 0, 20, -20, 0);
    idle(1);

    // random stream against the window-sum model
    do_flush();
    model_clear();
    for (int i = 0; i < 40; i++) begin
      send_model(int'($urandom_range(0, 24'hFFFFFF)) - 8388608,
                 int'($urandom_range(0, 24'hFFFFFF)) - 8388608,
                 ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2));
    end
    idle(2);

    // reset mid-stream clears outputs before the next clock edge
    drive(400, 400, 1);
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_out_data", 64'(out_data), 64'd0);
    check("async_reset_filled", 64'(filled), 64'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    send_exp(40, 8, 0, 10, 2, 0);
    send_exp(40, 8, 0, 20, 4, 0);
    idle(3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moving_average_nch.md
Name: moving_average_nch

Overview:
Parametrised multi-channel boxcar (moving-average) low-pass filter for the codec sample path. It sits between the audio-in sample stream and the audio-out write path. It generalises the existing two-channel, fixed-depth FIFO/accumulator filter to N channels, a configurable window and full-precision accumulation with no pre-shift truncation. It adds a bypass mode, a synchronous flush and explicit fill tracking.

Parameters:
WIDTH, 24, signed sample width per channel
LOG2_DEPTH, 6, log2 of window length (window = 2**LOG2_DEPTH samples, range 1..10)
CHANNELS, 2, number of independent channels packed in the data buses

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-low reset
in_valid  input  1  one sample set on in_data this cycle (driven from codec read_ready)
in_data  input  CHANNELS*WIDTH  signed samples; channel c at bits [c*WIDTH +: WIDTH]
bypass  input  1  1 = output raw input, 0 = output average
flush  input  1  synchronous clear of window and accumulators
out_valid  output  1  one-cycle strobe, out_data valid
out_data  output  CHANNELS*WIDTH  signed filtered (or bypassed) samples, same packing
filled  output  1  window holds 2**LOG2_DEPTH real samples

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, filled=0, all accumulators=0, write pointer=0, fill counter=0, state=FILL. Delay-line contents are not cleared; the FILL state masks them.
- Storage: per-channel circular delay line of 2**LOG2_DEPTH x WIDTH words. A single shared write pointer wraps from 2**LOG2_DEPTH-1 to 0. The word at the pointer is the oldest sample; it is read before being overwritten in the same cycle.
- Accumulator per channel: WIDTH+LOG2_DEPTH bits signed. It cannot overflow.
- On each in_valid cycle, per channel: acc <= acc + in - old, where old = 0 in FILL and the stored word in RUN. The new sample is written at the pointer, and the pointer advances.
- Output: out_valid rises exactly 1 cycle after an accepted in_valid and is high for one cycle.
  - bypass=0: out_data = (updated acc) >>> LOG2_DEPTH, arithmetic shift (floor toward -inf), taking the low WIDTH bits. The result is always in range.
  - bypass=1: out_data = registered in_data.
  - out_data holds its value between strobes.
- bypass is sampled with in_valid. The accumulators and delay line update regardless of bypass, so switching modes is glitch-free.
- State machine:
  - FILL: counts accepted samples. On the sample that brings the count to 2**LOG2_DEPTH, transition to RUN and set filled=1 in the same cycle as that out_valid.
  - RUN: steady state; stays in RUN until flush or reset.
  - During FILL the average is a zero-padded window sum / 2**LOG2_DEPTH (ramp-up). No division by the partial count.
- flush=1 (sampled on clock): accumulators=0, pointer=0, count=0, state=FILL, filled=0, out_valid=0 next cycle. flush wins over a simultaneous in_valid; that sample is dropped.
- in_valid on consecutive cycles is supported, at full throughput of one sample set per clock. Gaps of any length are allowed and state is held during them.
- No backpressure: the downstream consumer must accept out_valid when it fires.
- Reset asserted mid-stream aborts immediately. The first in_valid after release starts a fresh FILL.

Test Plan:
- WIDTH=24, LOG2_DEPTH=2, CHANNELS=2; ch0 step of 400 for 6 samples -> ch0 out_data 100, 200, 300, 400, 400, 400. filled rises with the 4th out_valid.
- Same config, ch1 constant -8 while ch0=0 -> ch1 out -2, -4, -6, -8, -8. ch0 stays 0 throughout, confirming channel independence.
- Rounding: ch0 impulse 1,0,0,0 -> out 0,0,0,0. Impulse -1,0,0,0 -> out -1,-1,-1,-1, then 0 once the -1 leaves the window.
- Extremes: ch0 = 0x7FFFFF for 8 samples -> final out 0x7FFFFF. Then 0x800000 for 8 samples -> final out 0x800000. No wrap.
- Mode and latency: bypass=1, in_valid pulses 1 cycle apart with values 5, -3 -> out_valid exactly 1 cycle later with 5 and -3. Switch to bypass=0 mid-stream -> next output equals the true window average.
- Flush and reset: after filled=1, assert flush together with in_valid(999) -> sample dropped, filled=0, next inputs ramp from zero. Pull reset low mid-stream -> out_data=0 and out_valid=0 asynchronously, before the next clock edge.
